// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: ALU codes, opcode/funct
// values, mux selects and FSM states.
package mips_ctrl_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b1010;
  localparam logic [3:0] ALU_SUB = 4'b1110;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_NOR = 4'b0011;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPE, S_RTYPEWB, S_BEQ, S_JUMP, S_IMMEX, S_IMMWB, S_ILLEGAL
  } state_t;

  // Immediate ALU ops reuse the funct decoder via their R-type equivalent.
  function automatic logic [5:0] imm_funct(input logic [5:0] op);
    case (op)
      OP_ADDI: return FN_ADD;
      OP_ANDI: return FN_AND;
      OP_ORI:  return FN_OR;
      OP_SLTI: return FN_SLT;
      default: return 6'b000000;
    endcase
  endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Controller <-> datapath signal bundle. master = control unit, slave = datapath.
interface mips_mc_ctrl_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic [3:0] ALUCtl;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic       PCEn;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       IllegalOp;

  modport master (
    input  Op, Funct, Zero,
    output ALUCtl, ALUSrcA, ALUSrcB, PCSource, PCEn, IorD, MemRead,
           MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, IllegalOp
  );

  modport slave (
    output Op, Funct, Zero,
    input  ALUCtl, ALUSrcA, ALUSrcB, PCSource, PCEn, IorD, MemRead,
           MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, IllegalOp
  );
endinterface

// File: rtl/mips_funct_dec.sv
// Combinational R-type funct decoder: ALU operation code plus a legal flag.
module mips_funct_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [3:0] o_aluctl,
  output logic       o_legal
);

  always_comb begin
    o_aluctl = ALU_ADD;
    o_legal  = 1'b1;
    case (i_funct)
      FN_ADD:  o_aluctl = ALU_ADD;
      FN_SUB:  o_aluctl = ALU_SUB;
      FN_AND:  o_aluctl = ALU_AND;
      FN_OR:   o_aluctl = ALU_OR;
      FN_NOR:  o_aluctl = ALU_NOR;
      FN_SLT:  o_aluctl = ALU_SLT;
      default: o_legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: Moore FSM plus memory-wait counter.
// Define IMM_ALU_EN to add addi/andi/ori/slti support (IMMEX/IMMWB states).
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
) (
  input logic            clk,
  input logic            rst,
  mips_mc_ctrl_if.master bus
);

  localparam logic [3:0] LAST = 4'(MEM_WAIT);

  state_t     r_state, w_next;
  logic [3:0] r_cnt, r_alu;
  logic       r_fn_ok, r_lw;
  logic [5:0] w_dec_fn;
  logic [3:0] w_dec_alu;
  logic       w_dec_ok, w_mem_state, w_last;
  logic       w_pcwrite, w_pccond, w_irw, w_regw, w_memw;

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_last      = (r_cnt == LAST);

`ifdef IMM_ALU_EN
  assign w_dec_fn = (bus.Op == OP_RTYPE) ? bus.Funct : imm_funct(bus.Op);
`else
  assign w_dec_fn = bus.Funct;
`endif

  mips_funct_dec u_fdec (
    .i_funct  (w_dec_fn),
    .o_aluctl (w_dec_alu),
    .o_legal  (w_dec_ok)
  );

  // ALU code and load/store kind are captured in DECODE so every later
  // state decodes from registers only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
      r_alu   <= ALU_ADD;
      r_fn_ok <= 1'b0;
      r_lw    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_mem_state && !w_last) ? r_cnt + 4'd1 : '0;
      if (r_state == S_DECODE) begin
        r_alu   <= w_dec_alu;
        r_fn_ok <= w_dec_ok;
        r_lw    <= (bus.Op == OP_LW);
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    bus.ALUCtl   = ALU_ADD;
    bus.ALUSrcA  = 1'b0;
    bus.ALUSrcB  = SRCB_REGB;
    bus.PCSource = PCS_ALU;
    bus.IorD     = 1'b0;
    bus.MemRead  = 1'b0;
    bus.RegDst   = 1'b0;
    bus.MemtoReg = 1'b0;
    w_pcwrite    = 1'b0;
    w_pccond     = 1'b0;
    w_irw        = 1'b0;
    w_regw       = 1'b0;
    w_memw       = 1'b0;
    case (r_state)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = SRCB_FOUR;
        if (w_last) begin
          w_irw     = 1'b1;
          w_pcwrite = 1'b1;
          w_next    = S_DECODE;
        end
      end
      S_DECODE: begin
        bus.ALUSrcB = SRCB_IMMSH;
        case (bus.Op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPE;
          OP_BEQ:       w_next = S_BEQ;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_next = S_ILLEGAL;
`ifdef IMM_ALU_EN
            if (w_dec_ok) w_next = S_IMMEX;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
        w_next      = r_lw ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        if (w_last) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_regw       = 1'b1;
        bus.MemtoReg = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWR: begin
        bus.IorD = 1'b1;
        if (w_last) begin
          w_memw = 1'b1;
          w_next = S_FETCH;
        end
      end
      S_RTYPE: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUCtl  = r_alu;
        w_next      = r_fn_ok ? S_RTYPEWB : S_ILLEGAL;
      end
      S_RTYPEWB: begin
        bus.ALUCtl = r_alu;
        bus.RegDst = 1'b1;
        w_regw     = 1'b1;
        w_next     = S_FETCH;
      end
      S_BEQ: begin
        bus.ALUSrcA  = 1'b1;
        bus.ALUCtl   = ALU_SUB;
        bus.PCSource = PCS_ALUOUT;
        w_pccond     = 1'b1;
        w_next       = S_FETCH;
      end
      S_JUMP: begin
        bus.PCSource = PCS_JUMP;
        w_pcwrite    = 1'b1;
        w_next       = S_FETCH;
      end
      S_IMMEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
        bus.ALUCtl  = r_alu;
        w_next      = S_IMMWB;
      end
      S_IMMWB: begin
        bus.ALUCtl = r_alu;
        w_regw     = 1'b1;
        w_next     = S_FETCH;
      end
      S_ILLEGAL: w_next = S_ILLEGAL;
      default:   w_next = S_FETCH;
    endcase
  end

  assign bus.PCEn      = ~rst & (w_pcwrite | (w_pccond & bus.Zero));
  assign bus.IRWrite   = ~rst & w_irw;
  assign bus.RegWrite  = ~rst & w_regw;
  assign bus.MemWrite  = ~rst & w_memw;
  assign bus.IllegalOp = (r_state == S_ILLEGAL);

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl: directed instruction table plus random
// instruction stream, both checked cycle-by-cycle against an instruction-level model.
module tb_mips_mc_ctrl;

  typedef struct packed {
    logic [3:0] alu;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcs;
    logic       pcen;
    logic       iord;
    logic       memrd;
    logic       memwr;
    logic       irw;
    logic       regdst;
    logic       memtoreg;
    logic       regw;
    logic       ill;
  } obs_t;

  typedef struct packed {
    obs_t val;
    obs_t care;
    logic zpcen;
  } exp_t;

  typedef struct {
    int         sel;
    logic [5:0] op;
    logic [5:0] fn;
    int         zmode;
    int         regw;
    int         pcen;
    int         memw;
    int         ill;
    string      name;
  } vec_t;

  localparam int D     = -1;
  localparam int ZF    = -2;
  localparam int A_AND = 4'b0000;
  localparam int A_OR  = 4'b0001;
  localparam int A_ADD = 4'b1010;
  localparam int A_SUB = 4'b1110;
  localparam int A_SLT = 4'b0101;
  localparam int A_NOR = 4'b0011;

  logic       clk;
  logic       rst;
  logic [5:0] op_d, fn_d;
  logic       zero_d;
  int         sel;
  int         n_pass, n_tot;
  exp_t       q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mips_mc_ctrl_if bus0 ();
  mips_mc_ctrl_if bus2 ();
  mips_mc_ctrl_if bus3 ();

  assign bus0.Op = op_d;  assign bus0.Funct = fn_d;  assign bus0.Zero = zero_d;
  assign bus2.Op = op_d;  assign bus2.Funct = fn_d;  assign bus2.Zero = zero_d;
  assign bus3.Op = op_d;  assign bus3.Funct = fn_d;  assign bus3.Zero = zero_d;

  mips_mc_ctrl #(.MEM_WAIT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mips_mc_ctrl #(.MEM_WAIT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
  mips_mc_ctrl #(.MEM_WAIT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  obs_t o0, o2, o3, obs;
  assign o0 = {bus0.ALUCtl, bus0.ALUSrcA, bus0.ALUSrcB, bus0.PCSource, bus0.PCEn, bus0.IorD,
               bus0.MemRead, bus0.MemWrite, bus0.IRWrite, bus0.RegDst, bus0.MemtoReg,
               bus0.RegWrite, bus0.IllegalOp};
  assign o2 = {bus2.ALUCtl, bus2.ALUSrcA, bus2.ALUSrcB, bus2.PCSource, bus2.PCEn, bus2.IorD,
               bus2.MemRead, bus2.MemWrite, bus2.IRWrite, bus2.RegDst, bus2.MemtoReg,
               bus2.RegWrite, bus2.IllegalOp};
  assign o3 = {bus3.ALUCtl, bus3.ALUSrcA, bus3.ALUSrcB, bus3.PCSource, bus3.PCEn, bus3.IorD,
               bus3.MemRead, bus3.MemWrite, bus3.IRWrite, bus3.RegDst, bus3.MemtoReg,
               bus3.RegWrite, bus3.IllegalOp};

  always_comb begin
    case (sel)
      0:       obs = o0;
      1:       obs = o2;
      default: obs = o3;
    endcase
  end

  function automatic int wait_of(input int s);
    return (s == 0) ? 0 : (s == 1) ? 2 : 3;
  endfunction

  // One expected cycle; D marks a field the controller may drive freely, ZF means PCEn must equal Zero.
  function automatic exp_t mk(input int alu, input int sa, input int sb, input int pcs,
                              input int pcen, input int iord, input int mr, input int mw,
                              input int irw, input int rd, input int m2r, input int rw,
                              input int ill);
    exp_t e;
    e = '0;
    if (alu  >= 0) begin e.val.alu      = 4'(alu);  e.care.alu      = '1; end
    if (sa   >= 0) begin e.val.srca     = 1'(sa);   e.care.srca     = 1'b1; end
    if (sb   >= 0) begin e.val.srcb     = 2'(sb);   e.care.srcb     = '1; end
    if (pcs  >= 0) begin e.val.pcs      = 2'(pcs);  e.care.pcs      = '1; end
    if (pcen >= 0) begin e.val.pcen     = 1'(pcen); e.care.pcen     = 1'b1; end
    if (pcen == ZF) begin e.zpcen = 1'b1;           e.care.pcen     = 1'b1; end
    if (iord >= 0) begin e.val.iord     = 1'(iord); e.care.iord     = 1'b1; end
    if (mr   >= 0) begin e.val.memrd    = 1'(mr);   e.care.memrd    = 1'b1; end
    if (mw   >= 0) begin e.val.memwr    = 1'(mw);   e.care.memwr    = 1'b1; end
    if (irw  >= 0) begin e.val.irw      = 1'(irw);  e.care.irw      = 1'b1; end
    if (rd   >= 0) begin e.val.regdst   = 1'(rd);   e.care.regdst   = 1'b1; end
    if (m2r  >= 0) begin e.val.memtoreg = 1'(m2r);  e.care.memtoreg = 1'b1; end
    if (rw   >= 0) begin e.val.regw     = 1'(rw);   e.care.regw     = 1'b1; end
    if (ill  >= 0) begin e.val.ill      = 1'(ill);  e.care.ill      = 1'b1; end
    return e;
  endfunction

  function automatic bit alu_of(input logic [5:0] fn, output int a);
    a = D;
    case (fn)
      6'b100000: a = A_ADD;
      6'b100010: a = A_SUB;
      6'b100100: a = A_AND;
      6'b100101: a = A_OR;
      6'b100111: a = A_NOR;
      6'b101010: a = A_SLT;
      default:   return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // Instruction-level model: expands one instruction into its expected cycle list.
  task automatic model(input int w, input logic [5:0] op, input logic [5:0] fn, output bit ill);
    int a;
    ill = 1'b0;
    for (int i = 0; i <= w; i++)
      q.push_back(mk(A_ADD, 0, 1, 0, (i == w) ? 1 : 0, 0, 1, 0, (i == w) ? 1 : 0, D, D, 0, 0));
    q.push_back(mk(A_ADD, 0, 3, D, 0, D, 0, 0, 0, D, D, 0, 0));
    case (op)
      6'b100011: begin
        q.push_back(mk(A_ADD, 1, 2, D, 0, D, 0, 0, 0, D, D, 0, 0));
        for (int i = 0; i <= w; i++) q.push_back(mk(D, D, D, D, 0, 1, 1, 0, 0, D, D, 0, 0));
        q.push_back(mk(D, D, D, D, 0, D, 0, 0, 0, 0, 1, 1, 0));
      end
      6'b101011: begin
        q.push_back(mk(A_ADD, 1, 2, D, 0, D, 0, 0, 0, D, D, 0, 0));
        for (int i = 0; i <= w; i++)
          q.push_back(mk(D, D, D, D, 0, 1, 0, (i == w) ? 1 : 0, 0, D, D, 0, 0));
      end
      6'b000000: begin
        if (alu_of(fn, a)) begin
          q.push_back(mk(a, 1, 0, D, 0, D, 0, 0, 0, D, D, 0, 0));
          q.push_back(mk(a, D, D, D, 0, D, 0, 0, 0, 1, 0, 1, 0));
        end else begin
          q.push_back(mk(D, 1, 0, D, 0, D, 0, 0, 0, D, D, 0, 0));
          ill = 1'b1;
        end
      end
      6'b000100: q.push_back(mk(A_SUB, 1, 0, 1, ZF, D, 0, 0, 0, D, D, 0, 0));
      6'b000010: q.push_back(mk(D, D, D, 2, 1, D, 0, 0, 0, D, D, 0, 0));
      default: begin
        a = D;
`ifdef IMM_ALU_EN
        case (op)
          6'b001000: a = A_ADD;
          6'b001100: a = A_AND;
          6'b001101: a = A_OR;
          6'b001010: a = A_SLT;
          default:   a = D;
        endcase
`endif
        if (a == D) ill = 1'b1;
        else begin
          q.push_back(mk(a, 1, 2, D, 0, D, 0, 0, 0, D, D, 0, 0));
          q.push_back(mk(a, D, D, D, 0, D, 0, 0, 0, 0, 0, 1, 0));
        end
      end
    endcase
    if (ill)
      for (int i = 0; i < 3; i++) q.push_back(mk(D, D, D, D, 0, D, 0, 0, 0, D, D, 0, 1));
  endtask

  task automatic chk_obs(input string name, input exp_t e);
    n_tot++;
    if (((obs ^ e.val) & e.care) == '0) n_pass++;
    else $display("FAIL %s W=%0d: got %b want %b care %b", name, wait_of(sel), obs, e.val, e.care);
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    n_tot++;
    if (got == want) n_pass++;
    else $display("FAIL %s W=%0d: got %0d want %0d", name, wait_of(sel), got, want);
  endtask

  task automatic chk_alu(input string name);
    n_tot++;
    if (obs.alu inside {4'b0000, 4'b0001, 4'b1010, 4'b1110, 4'b0101, 4'b0011}) n_pass++;
    else $display("FAIL %s_alu_code W=%0d: got %b want a defined ALU code", name, wait_of(sel), obs.alu);
  endtask

  function automatic exp_t reset_exp();
    return mk(A_ADD, 0, 1, 0, 0, 0, 1, 0, 0, D, D, 0, 0);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    zero_d = 1'b1;
    q.delete();
    @(posedge clk); #1;
    chk_obs("reset", reset_exp());
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input int zmode, input int max_cyc,
                           output int nrw, output int npc, output int nmw, output bit ill);
    exp_t e;
    int   k;
    op_d = op;
    fn_d = fn;
    nrw = 0; npc = 0; nmw = 0;
    model(wait_of(sel), op, fn, ill);
    k = 0;
    while (q.size() > 0 && k < max_cyc) begin
      e = q.pop_front();
      zero_d = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      if (e.zpcen) e.val.pcen = zero_d;
      @(negedge clk);
      chk_obs(name, e);
      chk_alu(name);
      nrw += int'(obs.regw);
      npc += int'(obs.pcen);
      nmw += int'(obs.memwr);
      @(posedge clk); #1;
      k++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t       tv[$];
    int         nrw, npc, nmw, a;
    bit         ill;
    exp_t       e;
    logic [5:0] rop, rfn;

    n_pass = 0; n_tot = 0; sel = 0;
    rst = 1'b1; op_d = '0; fn_d = '0; zero_d = 1'b0;

    tv.push_back('{0, 6'b000000, 6'b100000, 2, 1, 1, 0, 0, "add"});
    tv.push_back('{1, 6'b100011, 6'b010101, 2, 1, 1, 0, 0, "lw_w2"});
    tv.push_back('{0, 6'b101011, 6'b000000, 2, 0, 1, 1, 0, "sw_w0"});
    tv.push_back('{0, 6'b000100, 6'b000000, 1, 0, 2, 0, 0, "beq_z1"});
    tv.push_back('{0, 6'b000100, 6'b000000, 0, 0, 1, 0, 0, "beq_z0"});
    tv.push_back('{0, 6'b000010, 6'b111111, 2, 0, 2, 0, 0, "jump"});
    tv.push_back('{2, 6'b101011, 6'b100000, 2, 0, 1, 1, 0, "sw_w3"});
    tv.push_back('{1, 6'b000000, 6'b100010, 2, 1, 1, 0, 0, "sub_w2"});
    tv.push_back('{0, 6'b000000, 6'b100100, 2, 1, 1, 0, 0, "and"});
    tv.push_back('{2, 6'b000000, 6'b100101, 2, 1, 1, 0, 0, "or_w3"});
    tv.push_back('{0, 6'b000000, 6'b100111, 2, 1, 1, 0, 0, "nor"});
    tv.push_back('{1, 6'b000000, 6'b101010, 2, 1, 1, 0, 0, "slt_w2"});
    tv.push_back('{0, 6'b000000, 6'b000111, 2, 0, 1, 0, 1, "bad_funct"});
    tv.push_back('{0, 6'b111111, 6'b100000, 2, 0, 1, 0, 1, "bad_op"});
`ifdef IMM_ALU_EN
    tv.push_back('{0, 6'b001010, 6'b101010, 2, 1, 1, 0, 0, "slti"});
    tv.push_back('{1, 6'b001101, 6'b000000, 2, 1, 1, 0, 0, "ori_w2"});
`else
    tv.push_back('{0, 6'b001010, 6'b101010, 2, 0, 1, 0, 1, "slti"});
    tv.push_back('{1, 6'b001101, 6'b000000, 2, 0, 1, 0, 1, "ori_w2"});
`endif

    foreach (tv[i]) begin
      sel = tv[i].sel;
      do_reset();
      run_instr(tv[i].name, tv[i].op, tv[i].fn, tv[i].zmode, 1000, nrw, npc, nmw, ill);
      chk_int({tv[i].name, "_regwrite_pulses"}, nrw, tv[i].regw);
      chk_int({tv[i].name, "_pcen_pulses"}, npc, tv[i].pcen);
      chk_int({tv[i].name, "_memwrite_pulses"}, nmw, tv[i].memw);
      chk_int({tv[i].name, "_illegal_end"}, int'(obs.ill), tv[i].ill);
    end

    // sw with MEM_WAIT=3, reset asserted mid-cycle in the second MEMWR cycle.
    sel = 2;
    do_reset();
    run_instr("sw_abort", 6'b101011, 6'b000000, 2, 7, nrw, npc, nmw, ill);
    e = q.pop_front();
    zero_d = 1'b0;
    @(negedge clk);
    chk_obs("sw_abort_memwr1", e);
    nmw += int'(obs.memwr);
    #1 rst = 1'b1;
    #1 chk_obs("async_reset", reset_exp());
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      nmw += int'(obs.memwr);
    end
    chk_int("abort_memwrite_pulses", nmw, 0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    run_instr("after_abort_add", 6'b000000, 6'b100000, 2, 1000, nrw, npc, nmw, ill);
    chk_int("after_abort_regwrite", nrw, 1);

    // Random instruction stream on each wait configuration.
    for (int s = 0; s < 3; s++) begin
      sel = s;
      do_reset();
      for (int k = 0; k < 40; k++) begin
        case ($urandom_range(0, 9))
          0, 1:    rop = 6'b000000;
          2:       rop = 6'b100011;
          3:       rop = 6'b101011;
          4:       rop = 6'b000100;
          5:       rop = 6'b000010;
          6:       rop = 6'b001000;
          7:       rop = 6'b001100;
          8:       rop = 6'b001010;
          default: rop = 6'($urandom_range(0, 63));
        endcase
        if ($urandom_range(0, 3) != 0) begin
          case ($urandom_range(0, 5))
            0:       rfn = 6'b100000;
            1:       rfn = 6'b100010;
            2:       rfn = 6'b100100;
            3:       rfn = 6'b100101;
            4:       rfn = 6'b100111;
            default: rfn = 6'b101010;
          endcase
        end else begin
          rfn = 6'($urandom_range(0, 63));
        end
        run_instr("random", rop, rfn, 2, 1000, nrw, npc, nmw, ill);
        if (ill) do_reset();
      end
    end

    a = 0;
    $display("%0d/%0d checks passed", n_pass, n_tot + a);
    $finish;
  end

endmodule
